// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and default operand width for the MAC multiplier.
package mac_pkg;
   localparam int MAC_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} mul_state_t;
endpackage

// File: rtl/mac_mul_negate.sv
// mac_mul_negate: conditional two's-complement negate; driving neg with the sign bit yields |d|.
module mac_mul_negate #(
   parameter int WIDTH = 8
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   assign q = neg ? -d : d;
endmodule

// File: rtl/mac_seq_multiplier.sv
// mac_seq_multiplier: shift-add multiply responder for the MAC controller handshake.
// Define MAC_MUL_SIGNED_EN for two's-complement operands (adds a one-cycle FIX sign correction).
module mac_seq_multiplier
   import mac_pkg::*;
#(
   parameter int WIDTH = MAC_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reset_cmd,
   input  logic               load_op,
   input  logic               begin_mul,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic [2*WIDTH-1:0] product,
   output logic               end_mul,
   output logic               busy
);
   localparam int CW = $clog2(WIDTH + 1);
   mul_state_t state, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, a_mag, b_mag;
   logic [2*WIDTH-1:0] acc, acc_next, acc_fix;
   logic [CW-1:0] count, count_next;
   logic [WIDTH:0] sum;
`ifdef MAC_MUL_SIGNED_EN
   localparam mul_state_t LAST = FIX;
   // Latched operands cannot change mid-multiply (load_op aborts), so their signs serve as the recorded sign.
   mac_mul_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(a_reg[WIDTH-1]), .d(a_reg), .q(a_mag));
   mac_mul_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(b_reg[WIDTH-1]), .d(b_reg), .q(b_mag));
   mac_mul_negate #(.WIDTH(2*WIDTH)) u_fix (.neg(a_reg[WIDTH-1] ^ b_reg[WIDTH-1]), .d(acc), .q(acc_fix));
`else
   localparam mul_state_t LAST = DONE;
   assign a_mag = a_reg;
   assign b_mag = b_reg;
   assign acc_fix = acc;
`endif
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : {WIDTH{1'b0}})};
   always_comb begin
      state_next = state;
      acc_next = acc;
      count_next = count;
      if (load_op) begin
         state_next = IDLE;
         acc_next = '0;
         count_next = '0;
      end else if (begin_mul && (state == IDLE || state == DONE)) begin
         state_next = MUL;
         acc_next = {{WIDTH{1'b0}}, b_mag};
         count_next = CW'(WIDTH);
      end else if (state == MUL) begin
         acc_next = {sum, acc[WIDTH-1:1]};
         count_next = count - CW'(1);
         state_next = (count == CW'(1)) ? LAST : MUL;
      end else if (state == FIX) begin
         acc_next = acc_fix;
         state_next = DONE;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         acc <= '0;
         count <= '0;
         a_reg <= '0;
         b_reg <= '0;
      end else if (!reset_cmd) begin
         state <= IDLE;
         acc <= '0;
         count <= '0;
         a_reg <= '0;
         b_reg <= '0;
      end else begin
         state <= state_next;
         acc <= acc_next;
         count <= count_next;
         if (load_op) begin
            a_reg <= a_in;
            b_reg <= b_in;
         end
      end
   end
   assign end_mul = (state == DONE);
   assign product = end_mul ? acc : '0;
   assign busy = (state == MUL) || (state == FIX);
endmodule

// File: doc/mac_seq_multiplier.md
# mac_seq_multiplier

Sequential shift-add multiplier that acts as the responder to the MAC controller's multiply handshake. It captures operands on `load_op`, starts on `begin_mul`, iterates one partial product per cycle, and raises `end_mul` when the product is valid. The controller samples `end_mul` in its TEST state and accumulates the product in its ADD state. `end_mul` must therefore clear at the controller's LOAD/RUN edge so a stale completion is never seen.

## Interface
Parameters:
- `WIDTH`, 8: operand width in bits; the product is 2*WIDTH bits.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `reset_cmd`  in  1  synchronous, active-low clear issued by the controller.
- `load_op`  in  1  capture `a_in`/`b_in`; 1-cycle pulse.
- `begin_mul`  in  1  start multiplication; 1-cycle pulse.
- `a_in`  in  WIDTH  multiplicand.
- `b_in`  in  WIDTH  multiplier.
- `product`  out  2*WIDTH  result; valid while `end_mul`=1.
- `end_mul`  out  1  done level; held until cleared.
- `busy`  out  1  high while iterating.

## Operation
- States: IDLE, MUL, FIX (only with the macro), DONE.
- **Priority each edge:** `reset_cmd`=0, then `load_op`, then `begin_mul`.
- **`reset_cmd`=0:** registers cleared to 0, state → IDLE.
- **`load_op`=1, any state:**
  - latch `a_in`, `b_in`; clear `product`; `end_mul`→0; state → IDLE.
  - An in-flight multiply is aborted.
- **`begin_mul`=1 in IDLE or DONE:**
  - load accumulator: upper half = 0, lower half = latched multiplier.
  - count = WIDTH; `end_mul`→0; state → MUL.
  - In DONE this restarts the multiply with the same latched operands.
- **`begin_mul` in MUL/FIX:** ignored.
- **MUL, each cycle:**
  - if acc[0]=1, add the multiplicand to acc[2*WIDTH-1:WIDTH] with carry kept (WIDTH+1-bit add);
  - shift the whole accumulator right by 1, carry entering the MSB;
  - count−1.
  - When count reaches 0, go to DONE (or FIX).
- **DONE:** `product` = accumulator; `end_mul`=1; state held.
- **Arithmetic:** unsigned, exact, no overflow possible in 2*WIDTH bits.
- **Reset values:** `product`=0, `end_mul`=0, `busy`=0, state IDLE.

## Timing
- `begin_mul` sampled at edge E0.
- MUL steps occur on edges E1..E_WIDTH.
- `end_mul` and `product` are registered high/valid after edge E_WIDTH: WIDTH cycles latency, or WIDTH+1 with the macro.
- `end_mul` falls on the edge that samples `begin_mul` or `load_op`. It is therefore low in the controller's TEST cycle that follows RUN.
- `busy` = (state==MUL || state==FIX).
- Async `reset` mid-multiply: outputs go to reset values immediately.

## Configuration
- Macro: `MAC_MUL_SIGNED_EN`.
- **Defined:** operands are two's complement.
  - At `begin_mul`, the magnitudes of both operands are loaded and the sign XOR is recorded.
  - The unsigned iteration is unchanged.
  - FIX state (1 cycle) negates the accumulator if the signs differed.
  - −2^(WIDTH−1) magnitude is handled as an unsigned 2^(WIDTH−1).
- **Undefined:** unsigned only; no FIX state; latency WIDTH.

## Structure
- Package `mac_pkg`: state enum (IDLE, MUL, FIX, DONE) and the default `MAC_WIDTH`=8 constant.
- One sub-module, `mac_mul_negate` (parameterised two's-complement negate/abs unit). It is instantiated only under `MAC_MUL_SIGNED_EN`, for operand magnitude and result fixup.

## Test plan
- **Basic unsigned:** load 13, 11; `begin_mul` → `end_mul` rises 8 cycles later with `product`=16'h008F; `busy` high for 8 cycles.
- **Max operands:** load 255, 255 → `product`=16'hFE01. Load 0, 200 → `product`=0, `end_mul` still asserted.
- **Handshake with controller model:** 10 LOAD/RUN/TEST/ADD loops → `end_mul` is low in every TEST entry cycle, and accumulated sum matches the reference.
- **Abort:** `load_op` at cycle 4 of MUL with new operands 3, 7 → `end_mul` stays 0, state IDLE. The next `begin_mul` yields 21.
- **Resets:**
  - `reset_cmd`=0 in DONE → `product`=0, `end_mul`=0.
  - async `reset` low mid-MUL → immediate zero outputs.
  - `reset_cmd` and `load_op` in the same cycle → clear wins.
- **Signed (macro on):**
  - −3 × 5 → 16'hFFF1 after 9 cycles.
  - −128 × −128 → 16'h4000.
  - 127 × −1 → 16'hFF81.
